ahb_lite_arbiter2: RTL

- Two-master to one-slave AHB-Lite arbiter. It shares a single-slave AHB-Lite peripheral port, such as the timer register block, between the CPU (M0) and a second requester (M1), for example DMA or a debug bridge.
- Each master port carries a holding stage. A master that loses arbitration has its address phase captured and is wait-stated; it never sees a dropped transfer.
- Adds zero latency when uncontended. Sits between the bus matrix output and the slave's HSEL/HREADY inputs.

---
 rtl/ahb_pkg.sv | 24 ++
 rtl/ahb_lite_hold_stage.sv | 38 +++
 rtl/ahb_lite_arbiter2.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and the address-phase bundle shared by the arbiter and its hold stages.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef struct packed {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [3:0]  prot;
  } ahb_addr_t;

endpackage

// File: rtl/ahb_lite_hold_stage.sv
// Per-master holding stage: captures an address phase that was not accepted and
// replays it to the arbiter until it is.
module ahb_lite_hold_stage
  import ahb_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  ahb_addr_t i_live,
  input  logic      i_hready_m,
  input  logic      i_accept,
  output logic      o_req,
  output logic      o_hold_valid,
  output ahb_addr_t o_src
);

  logic      r_hold_valid;
  ahb_addr_t r_hold;
  logic      w_live_req;

  assign w_live_req = i_live.trans[1] & i_hready_m;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
    end else if (r_hold_valid) begin
      if (i_accept) r_hold_valid <= 1'b0;
    end else if (w_live_req && !i_accept) begin
      r_hold_valid <= 1'b1;
      r_hold       <= i_live;
    end
  end

  assign o_src        = r_hold_valid ? r_hold : i_live;
  assign o_req        = r_hold_valid | w_live_req;
  assign o_hold_valid = r_hold_valid;

endmodule

// File: rtl/ahb_lite_arbiter2.sv
// Two-master AHB-Lite arbiter in front of a single slave; zero added latency when
// uncontended, losers are captured in a hold stage and wait-stated.
module ahb_lite_arbiter2
  import ahb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter bit BURST_LOCK  = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  HTRANS_M0,
  input  logic [1:0]  HTRANS_M1,
  input  logic [31:0] HADDR_M0,
  input  logic [31:0] HADDR_M1,
  input  logic        HWRITE_M0,
  input  logic        HWRITE_M1,
  input  logic [2:0]  HSIZE_M0,
  input  logic [2:0]  HSIZE_M1,
  input  logic [3:0]  HPROT_M0,
  input  logic [3:0]  HPROT_M1,
  input  logic [31:0] HWDATA_M0,
  input  logic [31:0] HWDATA_M1,
  output logic        HREADY_M0,
  output logic        HREADY_M1,
  output logic [31:0] HRDATA_M0,
  output logic [31:0] HRDATA_M1,
  output logic        HRESP_M0,
  output logic        HRESP_M1,
  output logic        HSEL_S,
  output logic [31:0] HADDR_S,
  output logic [1:0]  HTRANS_S,
  output logic        HWRITE_S,
  output logic [2:0]  HSIZE_S,
  output logic [3:0]  HPROT_S,
  output logic [31:0] HWDATA_S,
  output logic        HREADY_S,
  input  logic        HREADYOUT_S,
  input  logic [31:0] HRDATA_S,
  input  logic        HRESP_S
);

  ahb_addr_t [1:0] w_live;
  ahb_addr_t [1:0] w_src;
  logic      [1:0] w_req;
  logic      [1:0] w_hold_valid;
  logic      [1:0] w_accept;
  logic      [1:0] w_hready_m;
  logic            w_arb;
  logic            w_gnt;

  logic r_gnt;
  logic r_last_grant;
  logic r_dp_valid;
  logic r_dp_owner;
  logic r_lock;

  assign w_live[0] = '{trans: HTRANS_M0, addr: HADDR_M0, write: HWRITE_M0,
                       size: HSIZE_M0, prot: HPROT_M0};
  assign w_live[1] = '{trans: HTRANS_M1, addr: HADDR_M1, write: HWRITE_M1,
                       size: HSIZE_M1, prot: HPROT_M1};

  assign w_hready_m[0] = (r_dp_valid && !r_dp_owner) ? HREADYOUT_S : !w_hold_valid[0];
  assign w_hready_m[1] = (r_dp_valid &&  r_dp_owner) ? HREADYOUT_S : !w_hold_valid[1];

  ahb_lite_hold_stage u_hold_m0 (
    .i_clk        (HCLK),
    .i_rst_n      (HRESETn),
    .i_live       (w_live[0]),
    .i_hready_m   (w_hready_m[0]),
    .i_accept     (w_accept[0]),
    .o_req        (w_req[0]),
    .o_hold_valid (w_hold_valid[0]),
    .o_src        (w_src[0])
  );

  ahb_lite_hold_stage u_hold_m1 (
    .i_clk        (HCLK),
    .i_rst_n      (HRESETn),
    .i_live       (w_live[1]),
    .i_hready_m   (w_hready_m[1]),
    .i_accept     (w_accept[1]),
    .o_req        (w_req[1]),
    .o_hold_valid (w_hold_valid[1]),
    .o_src        (w_src[1])
  );

  always_comb begin
    w_arb = r_last_grant;
    if (r_lock && w_req[r_last_grant] && (w_src[r_last_grant].trans == HTRANS_SEQ))
      w_arb = r_last_grant;
    else if (w_req == 2'b01)
      w_arb = 1'b0;
    else if (w_req == 2'b10)
      w_arb = 1'b1;
    else if (w_req == 2'b11)
      w_arb = ROUND_ROBIN ? ~r_last_grant : 1'b0;
  end

  // While the slave stalls, keep presenting the grant chosen in the last ready cycle
  assign w_gnt = HREADYOUT_S ? w_arb : r_gnt;

  assign w_accept[0] = HREADYOUT_S & w_req[0] & (w_gnt == 1'b0);
  assign w_accept[1] = HREADYOUT_S & w_req[1] & (w_gnt == 1'b1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
      r_dp_valid   <= 1'b0;
      r_dp_owner   <= 1'b0;
      r_lock       <= 1'b0;
    end else begin
      r_gnt <= w_gnt;
      if (HREADYOUT_S) begin
        r_dp_valid <= w_req[w_gnt];
        r_lock     <= BURST_LOCK & w_req[w_gnt];
        if (w_req[w_gnt]) begin
          r_dp_owner   <= w_gnt;
          r_last_grant <= w_gnt;
        end
      end
    end
  end

  assign HTRANS_S = (!HRESETn || (HREADYOUT_S && !w_req[w_gnt])) ? HTRANS_IDLE
                                                                  : w_src[w_gnt].trans;
  assign HSEL_S   = HTRANS_S[1];
  assign HADDR_S  = w_src[w_gnt].addr;
  assign HWRITE_S = w_src[w_gnt].write;
  assign HSIZE_S  = w_src[w_gnt].size;
  assign HPROT_S  = w_src[w_gnt].prot;
  assign HREADY_S = HREADYOUT_S;
  assign HWDATA_S = r_dp_owner ? HWDATA_M1 : HWDATA_M0;

  assign HREADY_M0 = w_hready_m[0];
  assign HREADY_M1 = w_hready_m[1];
  assign HRDATA_M0 = (r_dp_valid && !r_dp_owner) ? HRDATA_S : '0;
  assign HRDATA_M1 = (r_dp_valid &&  r_dp_owner) ? HRDATA_S : '0;
  assign HRESP_M0  = (r_dp_valid && !r_dp_owner) ? HRESP_S : HRESP_OKAY;
  assign HRESP_M1  = (r_dp_valid &&  r_dp_owner) ? HRESP_S : HRESP_OKAY;

endmodule
